uart_rx_fsm: RTL and testbench

- Control state machine for the UART receiver.
- Detects a falling edge on the serial line and runs the oversampling edge/bit counters.
- Issues one-cycle enable strobes, in frame order, to the data sampler, start checker, deserializer, parity checker and stop checker.
- Reads the checker error flags and produces the frame-level data_valid and frame_err pulses consumed by the RX top.

---
 rtl/uart_rx_pkg.sv | 27 ++
 rtl/uart_rx_edge_bit_cnt.sv | 33 +++
 rtl/uart_rx_fsm.sv | 148 ++++++++++++++
 tb/tb_uart_rx_fsm.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receiver control path.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    // Default number of data bits per frame
    localparam int DEF_DATA_WIDTH = 8;

    // Offset above mid-bit at which the majority-of-3 sample is final
    localparam int CHK_OFS = 2;

    // Supported oversampling ratios
    localparam int PRESCALE_X8  = 8;
    localparam int PRESCALE_X16 = 16;
    localparam int PRESCALE_X32 = 32;

    function automatic logic prescale_legal(input int p);
        return (p == PRESCALE_X8) || (p == PRESCALE_X16) || (p == PRESCALE_X32);
    endfunction

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// Oversample edge counter and frame bit counter. Both hold at zero while
// cnt_en is low; the edge counter wraps at prescale-1 and bumps the bit count.
import uart_rx_pkg::*;

module uart_rx_edge_bit_cnt #(
    parameter int PRESCALE_W = 6,
    parameter int BIT_CNT_W  = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  cnt_en,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [BIT_CNT_W-1:0]  bit_cnt
);

    // Count oversample edges within a bit and bits within a frame
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (!cnt_en) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (edge_cnt == prescale - 1'b1) begin
            edge_cnt <= '0;
            bit_cnt  <= bit_cnt + 1'b1;
        end else begin
            edge_cnt <= edge_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receiver control FSM: start detection, per-bit checker/deserializer
// strobes, and frame-level data_valid / frame_err pulses.
// Optional: define UART_RX_ERR_CNT_EN to build the saturating errored-frame
// counter on err_cnt; otherwise err_cnt is tied to zero.
import uart_rx_pkg::*;

module uart_rx_fsm #(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int PRESCALE_W = 6,
    parameter int BIT_CNT_W  = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  rx_in,
    input  logic                  par_en,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  start_err,
    input  logic                  par_err,
    input  logic                  stop_err,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [BIT_CNT_W-1:0]  bit_cnt,
    output logic                  dat_samp_en,
    output logic                  start_chk_en,
    output logic                  deser_en,
    output logic                  par_chk_en,
    output logic                  stop_chk_en,
    output logic                  data_valid,
    output logic                  frame_err,
    output logic [7:0]            err_cnt
);

    state_t                state;
    logic [PRESCALE_W-1:0] pre_q;
    logic                  par_q;
    logic                  err_flag;

    logic [PRESCALE_W-1:0] chk;
    logic [PRESCALE_W-1:0] last;
    logic                  at_chk_m1;
    logic                  at_chk_p1;
    logic                  at_last;
    logic                  start_bad;
    logic                  glitch;
    logic                  stop_done;
    logic                  frame_ok;
    logic                  cnt_en;

    // Frame timing derived from the prescale latched at start detection
    assign chk       = (pre_q >> 1) + PRESCALE_W'(CHK_OFS);
    assign last      = pre_q - 1'b1;
    assign at_chk_m1 = (edge_cnt == chk - 1'b1);
    assign at_chk_p1 = (edge_cnt == chk + 1'b1);
    assign at_last   = (edge_cnt == last);

    // With prescale 8, CHK+1 coincides with LAST, so the checker's flag must be
    // taken straight from the port; otherwise use the copy captured at CHK+1.
    assign start_bad = at_chk_p1 ? start_err : err_flag;
    assign glitch    = (state == START) && at_last && start_bad;
    assign stop_done = (state == STOP) && at_chk_p1;
    assign frame_ok  = !stop_err && !err_flag;

    // Counters run whenever the next state is not IDLE (equals next-state != IDLE)
    always_comb begin
        cnt_en = 1'b0;
        if (state == IDLE) cnt_en = !rx_in;
        else               cnt_en = !(glitch || stop_done);
    end

    uart_rx_edge_bit_cnt #(
        .PRESCALE_W (PRESCALE_W),
        .BIT_CNT_W  (BIT_CNT_W)
    ) u_cnt (
        .CLK      (CLK),
        .RST      (RST),
        .cnt_en   (cnt_en),
        .prescale (pre_q),
        .edge_cnt (edge_cnt),
        .bit_cnt  (bit_cnt)
    );

    // State, latched frame config, error flag and registered strobes/pulses.
    // Strobes look one edge ahead so they are high exactly while edge_cnt==CHK.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state        <= IDLE;
            pre_q        <= '0;
            par_q        <= 1'b0;
            err_flag     <= 1'b0;
            dat_samp_en  <= 1'b0;
            start_chk_en <= 1'b0;
            deser_en     <= 1'b0;
            par_chk_en   <= 1'b0;
            stop_chk_en  <= 1'b0;
            data_valid   <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            dat_samp_en  <= cnt_en;
            start_chk_en <= (state == START)  && at_chk_m1;
            deser_en     <= (state == DATA)   && at_chk_m1;
            par_chk_en   <= (state == PARITY) && at_chk_m1;
            stop_chk_en  <= (state == STOP)   && at_chk_m1;
            data_valid   <= stop_done && frame_ok;
            frame_err    <= stop_done && !frame_ok;

            case (state)
                IDLE: begin
                    if (!rx_in) begin
                        state    <= START;
                        pre_q    <= prescale;
                        par_q    <= par_en;
                        err_flag <= 1'b0;
                    end
                end
                START: begin
                    if (at_chk_p1) err_flag <= start_err;
                    if (at_last)   state    <= start_bad ? IDLE : DATA;
                end
                DATA: begin
                    if (at_last && (bit_cnt == BIT_CNT_W'(DATA_WIDTH)))
                        state <= par_q ? PARITY : STOP;
                end
                PARITY: begin
                    if (at_chk_p1) err_flag <= par_err;
                    if (at_last)   state    <= STOP;
                end
                STOP: begin
                    // Leave early so a back-to-back start bit is caught
                    if (at_chk_p1) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef UART_RX_ERR_CNT_EN
    logic err_inc;
    assign err_inc = (stop_done && !frame_ok) || glitch;

    // Saturating count of errored frames and start-bit glitches
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)                          err_cnt <= 8'd0;
        else if (err_inc && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
`else
    assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed bench for uart_rx_fsm: drives serial frames, models the three
// checkers, and checks strobe timing and frame pulses per scenario.
module tb_uart_rx_fsm;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       rx_in = 1'b1;
    logic       par_en = 1'b0;
    logic [5:0] prescale = 6'd8;
    logic       start_err, par_err, stop_err;
    logic [5:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic       dat_samp_en, start_chk_en, deser_en, par_chk_en, stop_chk_en;
    logic       data_valid, frame_err;
    logic [7:0] err_cnt;

    logic cfg_start_err = 1'b0, cfg_par_err = 1'b0, cfg_stop_err = 1'b0;

    int checks = 0, failures = 0;
    int exp_err;

    // monitor records
    int mon_chk = 6;
    int n_deser, bad_edge, deser_first, deser_last;
    int n_start, start_edge, start_bit_or;
    int n_par, par_edge, par_bit, n_stop, stop_edge;
    int n_dv, dv_edge, dv_bit, n_fe, fe_edge, fe_bit, n_both;
    int n_samp, samp_edge, prev_edge, prev_bit;

    uart_rx_fsm dut (
        .CLK(CLK), .RST(RST), .rx_in(rx_in), .par_en(par_en), .prescale(prescale),
        .start_err(start_err), .par_err(par_err), .stop_err(stop_err),
        .edge_cnt(edge_cnt), .bit_cnt(bit_cnt), .dat_samp_en(dat_samp_en),
        .start_chk_en(start_chk_en), .deser_en(deser_en), .par_chk_en(par_chk_en),
        .stop_chk_en(stop_chk_en), .data_valid(data_valid), .frame_err(frame_err),
        .err_cnt(err_cnt)
    );

    always #5 CLK = ~CLK;

    // Checker models: flag becomes valid the cycle after its strobe and holds
    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            start_err <= 1'b0; par_err <= 1'b0; stop_err <= 1'b0;
        end else begin
            if (start_chk_en) start_err <= cfg_start_err;
            if (par_chk_en)   par_err   <= cfg_par_err;
            if (stop_chk_en)  stop_err  <= cfg_stop_err;
        end
    end

    // Event recorder, sampled on the inactive edge
    always @(negedge CLK) begin
        if (deser_en) begin
            if (n_deser == 0) deser_first = int'(bit_cnt);
            deser_last = int'(bit_cnt);
            n_deser++;
            if (int'(edge_cnt) != mon_chk) bad_edge++;
        end
        if (start_chk_en) begin n_start++; start_edge = int'(edge_cnt); start_bit_or |= int'(bit_cnt); end
        if (par_chk_en)   begin n_par++; par_edge = int'(edge_cnt); par_bit = int'(bit_cnt); end
        if (stop_chk_en)  begin n_stop++; stop_edge = int'(edge_cnt); end
        if (data_valid)   begin n_dv++; dv_edge = prev_edge; dv_bit = prev_bit; end
        if (frame_err)    begin n_fe++; fe_edge = prev_edge; fe_bit = prev_bit; end
        if (data_valid && frame_err) n_both++;
        if (dat_samp_en)  begin n_samp++; samp_edge = int'(edge_cnt); end
        prev_edge = int'(edge_cnt);
        prev_bit  = int'(bit_cnt);
    end

    task automatic mon_clear();
        n_deser = 0; bad_edge = 0; deser_first = -1; deser_last = -1;
        n_start = 0; start_edge = -1; start_bit_or = 0;
        n_par = 0; par_edge = -1; par_bit = -1; n_stop = 0; stop_edge = -1;
        n_dv = 0; dv_edge = -1; dv_bit = -1; n_fe = 0; fe_edge = -1; fe_bit = -1;
        n_both = 0; n_samp = 0; samp_edge = -1;
    endtask

    task automatic drive_bit(input logic v, input int cyc);
        rx_in = v;
        repeat (cyc) @(negedge CLK);
    endtask

    task automatic send_frame(input logic [7:0] d, input int cyc, input bit has_par,
                              input logic pv, input int stop_len);
        drive_bit(1'b0, cyc);
        for (int i = 0; i < 8; i++) drive_bit(d[i], cyc);
        if (has_par) drive_bit(pv, cyc);
        drive_bit(1'b1, stop_len);
    endtask

    task automatic test_reset();
        #3;
        checks++; if ({edge_cnt, bit_cnt, dat_samp_en, start_chk_en, deser_en, par_chk_en,
                       stop_chk_en, data_valid, frame_err, err_cnt} !== '0) begin
            failures++; $display("FAIL reset_outputs got=%h exp=0", {edge_cnt, bit_cnt, dat_samp_en,
                start_chk_en, deser_en, par_chk_en, stop_chk_en, data_valid, frame_err, err_cnt});
        end
        @(negedge CLK); RST = 1'b1;
        repeat (3) @(negedge CLK);
        checks++; if ({edge_cnt, bit_cnt, dat_samp_en} !== '0) begin
            failures++; $display("FAIL idle_after_reset edge=%0d bit=%0d samp=%0b exp=0", edge_cnt, bit_cnt, dat_samp_en);
        end
    endtask

    task automatic test_clean_p8();
        prescale = 6'd8; par_en = 1'b0; cfg_start_err = 0; cfg_par_err = 0; cfg_stop_err = 0;
        mon_clear(); mon_chk = 6;
        send_frame(8'hA5, 8, 0, 1'b0, 8);
        drive_bit(1'b1, 4);
        checks++; if (n_deser !== 8) begin failures++; $display("FAIL p8_deser_count got=%0d exp=8", n_deser); end
        checks++; if (bad_edge !== 0) begin failures++; $display("FAIL p8_deser_edge bad=%0d exp=0", bad_edge); end
        checks++; if (deser_first !== 1 || deser_last !== 8) begin failures++; $display("FAIL p8_deser_bits got=%0d..%0d exp=1..8", deser_first, deser_last); end
        checks++; if (n_start !== 1 || start_edge !== 6) begin failures++; $display("FAIL p8_start_chk n=%0d edge=%0d exp=1,6", n_start, start_edge); end
        checks++; if (n_stop !== 1 || stop_edge !== 6) begin failures++; $display("FAIL p8_stop_chk n=%0d edge=%0d exp=1,6", n_stop, stop_edge); end
        checks++; if (n_dv !== 1 || dv_edge !== 7 || dv_bit !== 9) begin failures++; $display("FAIL p8_data_valid n=%0d edge=%0d bit=%0d exp=1,7,9", n_dv, dv_edge, dv_bit); end
        checks++; if (n_fe !== 0 || n_par !== 0) begin failures++; $display("FAIL p8_no_err fe=%0d par=%0d exp=0,0", n_fe, n_par); end
    endtask

    task automatic test_parity_err_p16();
        prescale = 6'd16; par_en = 1'b1; cfg_par_err = 1'b1;
        mon_clear(); mon_chk = 10;
        send_frame(8'h3C, 16, 1, 1'b1, 16);
        drive_bit(1'b1, 4);
        cfg_par_err = 1'b0;
        exp_err = 0;
`ifdef UART_RX_ERR_CNT_EN
        exp_err = 1;
`endif
        checks++; if (n_par !== 1 || par_edge !== 10 || par_bit !== 9) begin failures++; $display("FAIL p16_par_chk n=%0d edge=%0d bit=%0d exp=1,10,9", n_par, par_edge, par_bit); end
        checks++; if (n_fe !== 1 || fe_edge !== 11 || fe_bit !== 10) begin failures++; $display("FAIL p16_frame_err n=%0d edge=%0d bit=%0d exp=1,11,10", n_fe, fe_edge, fe_bit); end
        checks++; if (n_dv !== 0 || n_both !== 0) begin failures++; $display("FAIL p16_no_valid dv=%0d both=%0d exp=0,0", n_dv, n_both); end
        checks++; if (n_deser !== 8 || bad_edge !== 0) begin failures++; $display("FAIL p16_deser n=%0d bad=%0d exp=8,0", n_deser, bad_edge); end
        checks++; if (int'(err_cnt) !== exp_err) begin failures++; $display("FAIL p16_err_cnt got=%0d exp=%0d", err_cnt, exp_err); end
    endtask

    task automatic test_start_glitch();
        prescale = 6'd16; par_en = 1'b0; cfg_start_err = 1'b1;
        mon_clear(); mon_chk = 10;
        drive_bit(1'b0, 3);
        drive_bit(1'b1, 20);
        cfg_start_err = 1'b0;
        exp_err = 0;
`ifdef UART_RX_ERR_CNT_EN
        exp_err = 2;
`endif
        checks++; if (n_start !== 1 || start_edge !== 10) begin failures++; $display("FAIL glitch_start_chk n=%0d edge=%0d exp=1,10", n_start, start_edge); end
        checks++; if (n_samp !== 15 || samp_edge !== 15) begin failures++; $display("FAIL glitch_abort_at_last samp=%0d last=%0d exp=15,15", n_samp, samp_edge); end
        checks++; if (n_deser !== 0 || n_dv !== 0 || n_fe !== 0) begin failures++; $display("FAIL glitch_no_pulses deser=%0d dv=%0d fe=%0d exp=0", n_deser, n_dv, n_fe); end
        checks++; if (int'(err_cnt) !== exp_err) begin failures++; $display("FAIL glitch_err_cnt got=%0d exp=%0d", err_cnt, exp_err); end
    endtask

    task automatic test_back_to_back();
        prescale = 6'd16; par_en = 1'b0;
        mon_clear(); mon_chk = 10;
        send_frame(8'h5A, 16, 0, 1'b0, 12);
        send_frame(8'hC3, 16, 0, 1'b0, 16);
        drive_bit(1'b1, 4);
        checks++; if (n_dv !== 2 || n_fe !== 0) begin failures++; $display("FAIL b2b_valid dv=%0d fe=%0d exp=2,0", n_dv, n_fe); end
        checks++; if (n_start !== 2 || start_bit_or !== 0) begin failures++; $display("FAIL b2b_bit_restart starts=%0d bitor=%0d exp=2,0", n_start, start_bit_or); end
        checks++; if (n_deser !== 16 || bad_edge !== 0) begin failures++; $display("FAIL b2b_deser n=%0d bad=%0d exp=16,0", n_deser, bad_edge); end
        checks++; if (dv_edge !== 11 || dv_bit !== 9) begin failures++; $display("FAIL b2b_dv_pos edge=%0d bit=%0d exp=11,9", dv_edge, dv_bit); end
    endtask

    task automatic test_reset_mid_frame();
        prescale = 6'd8; par_en = 1'b0;
        mon_clear(); mon_chk = 6;
        drive_bit(1'b0, 8);
        drive_bit(1'b1, 8); drive_bit(1'b0, 8); drive_bit(1'b1, 8);
        drive_bit(1'b1, 3);
        checks++; if (bit_cnt !== 4'd4 || edge_cnt !== 6'd3) begin failures++; $display("FAIL pre_reset_pos bit=%0d edge=%0d exp=4,3", bit_cnt, edge_cnt); end
        #2 RST = 1'b0;
        #1;
        checks++; if ({edge_cnt, bit_cnt, dat_samp_en, start_chk_en, deser_en, par_chk_en,
                       stop_chk_en, data_valid, frame_err, err_cnt} !== '0) begin
            failures++; $display("FAIL midframe_reset_outputs edge=%0d bit=%0d samp=%0b err_cnt=%0d exp=0", edge_cnt, bit_cnt, dat_samp_en, err_cnt);
        end
        rx_in = 1'b1;
        @(negedge CLK); @(negedge CLK); RST = 1'b1;
        drive_bit(1'b1, 3);
        mon_clear();
        send_frame(8'h81, 8, 0, 1'b0, 8);
        drive_bit(1'b1, 4);
        checks++; if (n_dv !== 1 || n_fe !== 0 || n_deser !== 8) begin failures++; $display("FAIL post_reset_frame dv=%0d fe=%0d deser=%0d exp=1,0,8", n_dv, n_fe, n_deser); end
    endtask

    task automatic test_latch_change();
        prescale = 6'd8; par_en = 1'b0;
        mon_clear(); mon_chk = 6;
        fork
            send_frame(8'h96, 8, 0, 1'b0, 8);
            begin repeat (30) @(negedge CLK); prescale = 6'd16; par_en = 1'b1; end
        join
        drive_bit(1'b1, 4);
        checks++; if (n_par !== 0 || n_deser !== 8 || bad_edge !== 0) begin failures++; $display("FAIL latch_cur_frame par=%0d deser=%0d bad=%0d exp=0,8,0", n_par, n_deser, bad_edge); end
        checks++; if (n_dv !== 1 || dv_edge !== 7 || dv_bit !== 9) begin failures++; $display("FAIL latch_cur_valid n=%0d edge=%0d bit=%0d exp=1,7,9", n_dv, dv_edge, dv_bit); end
        mon_clear(); mon_chk = 10;
        send_frame(8'h0F, 16, 1, 1'b0, 16);
        drive_bit(1'b1, 4);
        checks++; if (n_par !== 1 || par_edge !== 10 || bad_edge !== 0) begin failures++; $display("FAIL latch_next_par n=%0d edge=%0d bad=%0d exp=1,10,0", n_par, par_edge, bad_edge); end
        checks++; if (n_dv !== 1 || dv_edge !== 11 || dv_bit !== 10) begin failures++; $display("FAIL latch_next_valid n=%0d edge=%0d bit=%0d exp=1,11,10", n_dv, dv_edge, dv_bit); end
    endtask

    initial begin
        mon_clear();
        test_reset();
        test_clean_p8();
        test_parity_err_p16();
        test_start_glitch();
        test_back_to_back();
        test_reset_mid_frame();
        test_latch_change();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
